// File: rtl/risc15_pkg.sv
// Shared ISA field positions, LM/SM opcodes and issue-stage state encoding.
package risc15_pkg;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam int         OPC_HI  = 15;
  localparam int         OPC_LO  = 12;
  localparam int         MASK_LO = 0;
  localparam int         MASK_HI = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_SEQ    = 2'd2;

  function automatic logic is_lmsm(input logic [15:0] ir);
    return (ir[OPC_HI:OPC_LO] == OP_LM) || (ir[OPC_HI:OPC_LO] == OP_SM);
  endfunction
endpackage

// File: rtl/lsb_clear8.sv
// Lowest-set-bit clear for the LM/SM register mask, plus a one-bit-left flag.
module lsb_clear8 (
  input  logic [7:0] mask_i,
  output logic [7:0] next_mask_o,
  output logic       single_bit_o
);
  always_comb begin
    next_mask_o  = mask_i & (mask_i - 8'd1);
    single_bit_o = (mask_i != 8'd0) && (next_mask_o == 8'd0);
  end
endmodule

// File: rtl/lmsm_issue.sv
// Issue stage: passes instructions to decode, expanding LM/SM into per-register micro-ops.
// Option: LMSM_ZERO_DROP_EN drops LM/SM with an empty mask instead of issuing it once.
module lmsm_issue
  import risc15_pkg::*;
#(
  parameter int IW    = 16,
  parameter int AW    = 16,
  parameter int MASKW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_ir,
  input  logic [AW-1:0] in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_ir,
  output logic [AW-1:0] out_pc,
  output logic [2:0]    out_seq,
  output logic          out_last
);
  logic [1:0]    state_q, state_d, ld_state;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    seq_q, seq_d;
  logic [7:0]    next_mask;
  logic          single_bit, accept, pop;

  lsb_clear8 u_lsb (
    .mask_i      (ir_q[MASK_HI:MASK_LO]),
    .next_mask_o (next_mask),
    .single_bit_o(single_bit)
  );

  // Classification of the incoming instruction decides its state on load.
  always_comb begin
    ld_state = ST_SINGLE;
    if (is_lmsm(in_ir)) begin
      if (in_ir[MASK_HI:MASK_LO] != 8'd0) ld_state = ST_SEQ;
`ifdef LMSM_ZERO_DROP_EN
      else                                ld_state = ST_IDLE;
`else
      else                                ld_state = ST_SINGLE;
`endif
    end
  end

  always_comb begin
    out_valid = (state_q != ST_IDLE);
    out_last  = (state_q == ST_SINGLE) || ((state_q == ST_SEQ) && single_bit);
    in_ready  = !flush && ((state_q == ST_IDLE) || (out_ready && out_last));
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    seq_d     = seq_q;
    // Flush wins over both handshakes; IR/PC may go stale since out_valid drops.
    if (flush) begin
      state_d = ST_IDLE;
      seq_d   = 3'd0;
    end else if (accept) begin
      state_d = ld_state;
      ir_d    = in_ir;
      pc_d    = in_pc;
      seq_d   = 3'd0;
    end else if (pop) begin
      if (out_last) begin
        state_d = ST_IDLE;
        seq_d   = 3'd0;
      end else begin
        ir_d  = {ir_q[IW-1:MASK_HI+1], next_mask};
        seq_d = seq_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      seq_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      seq_q   <= seq_d;
    end
  end

  assign out_ir  = ir_q;
  assign out_pc  = pc_q;
  assign out_seq = seq_q;
endmodule
